// File: rtl/weight_bank.sv
// Weight store for the epoch trainer: sources weights on the shared bus, captures updates, commits at epoch end.
// Flags, count and stored weights update at the epoch-end edge; bus drive follows `direction` combinationally.
module weight_bank #(
  parameter int             TAM        = 16,
  parameter logic [TAM-1:0] INIT_W     = 16'h3C00,
  parameter int             MAX_EPOCAS = 32,
  parameter int             CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             direction,
  inout  logic [TAM-1:0]   w0,
  inout  logic [TAM-1:0]   w1,
  inout  logic [TAM-1:0]   w2,
  input  logic             start,
  input  logic             host_wr_en,
  input  logic [1:0]       host_sel,
  input  logic [TAM-1:0]   host_wdata,
  output logic [TAM-1:0]   host_rdata,
  output logic             trn_reset,
  output logic             busy,
  output logic             converged,
  output logic             timeout,
  output logic [CNT_W-1:0] epoch_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [TAM-1:0]   r_w0, r_w1, r_w2;
  logic [TAM-1:0]   r_cap_w0, r_cap_w1, r_cap_w2;
  logic             r_dir_q;
  logic             r_trn_reset, r_busy, r_converged, r_timeout;
  logic [CNT_W-1:0] r_epoch_count;

  logic             w_epoch_end;
  logic             w_match;
  logic             w_host_ok;
  logic [CNT_W-1:0] w_cnt_nxt;

  // The bank only drives while the trainer is listening; never registered, so no overlap.
  assign w0 = direction ? {TAM{1'bz}} : r_w0;
  assign w1 = direction ? {TAM{1'bz}} : r_w1;
  assign w2 = direction ? {TAM{1'bz}} : r_w2;

  assign w_epoch_end = r_dir_q && !direction;
  assign w_match     = (r_cap_w0 == r_w0) && (r_cap_w1 == r_w1) && (r_cap_w2 == r_w2);
  assign w_host_ok   = host_wr_en && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cnt_nxt   = r_epoch_count + CNT_W'(1);

  always_comb begin
    host_rdata = '0;
    case (host_sel)
      2'd0:    host_rdata = r_w0;
      2'd1:    host_rdata = r_w1;
      2'd2:    host_rdata = r_w2;
      default: host_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_w0 <= '0;
      r_cap_w1 <= '0;
      r_cap_w2 <= '0;
      r_dir_q  <= 1'b0;
    end else begin
      r_dir_q <= direction;
      if (direction) begin
        r_cap_w0 <= w0;
        r_cap_w1 <= w1;
        r_cap_w2 <= w2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_w0          <= INIT_W;
      r_w1          <= INIT_W;
      r_w2          <= INIT_W;
      r_trn_reset   <= 1'b1;
      r_busy        <= 1'b0;
      r_converged   <= 1'b0;
      r_timeout     <= 1'b0;
      r_epoch_count <= '0;
    end else begin
      if (w_host_ok) begin
        case (host_sel)
          2'd0:    r_w0 <= host_wdata;
          2'd1:    r_w1 <= host_wdata;
          2'd2:    r_w2 <= host_wdata;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          r_trn_reset <= 1'b1;
          r_busy      <= 1'b0;
          if (start) begin
            r_state       <= S_LOAD;
            r_busy        <= 1'b1;
            r_epoch_count <= '0;
            r_converged   <= 1'b0;
            r_timeout     <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state     <= S_RUN;
          r_trn_reset <= 1'b0;
          r_busy      <= 1'b1;
        end
        S_RUN: begin
          if (w_epoch_end) begin
            r_epoch_count <= w_cnt_nxt;
            if (w_match) begin
              r_converged <= 1'b1;
              r_state     <= S_DONE;
              r_trn_reset <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_w0 <= r_cap_w0;
              r_w1 <= r_cap_w1;
              r_w2 <= r_cap_w2;
              // Timeout fires before the counter can wrap.
              if (w_cnt_nxt == CNT_W'(MAX_EPOCAS)) begin
                r_timeout   <= 1'b1;
                r_state     <= S_DONE;
                r_trn_reset <= 1'b1;
                r_busy      <= 1'b0;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign trn_reset   = r_trn_reset;
  assign busy        = r_busy;
  assign converged   = r_converged;
  assign timeout     = r_timeout;
  assign epoch_count = r_epoch_count;

endmodule

// File: tb/tb_weight_bank.sv
module tb_weight_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        direction = 1'b0;
  logic        start = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [1:0]  host_sel = 2'd0;
  logic [15:0] host_wdata = 16'h0;
  logic [15:0] host_rdata;
  logic        trn_reset, busy, converged, timeout;
  logic [5:0]  epoch_count;
  logic [15:0] tb_w0 = 16'h0, tb_w1 = 16'h0, tb_w2 = 16'h0;
  wire  [15:0] w0, w1, w2;

  int n_pass = 0;
  int n_total = 0;

  assign w0 = direction ? tb_w0 : 16'hzzzz;
  assign w1 = direction ? tb_w1 : 16'hzzzz;
  assign w2 = direction ? tb_w2 : 16'hzzzz;

  always #5 clk = ~clk;

  weight_bank #(.TAM(16), .INIT_W(16'h3C00), .MAX_EPOCAS(4), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .direction(direction),
    .w0(w0), .w1(w1), .w2(w2),
    .start(start), .host_wr_en(host_wr_en), .host_sel(host_sel),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .trn_reset(trn_reset), .busy(busy), .converged(converged),
    .timeout(timeout), .epoch_count(epoch_count)
  );

  typedef struct {
    logic        dir, st, wr;
    logic [1:0]  sel;
    logic [15:0] wd, d0, d1, d2;
    logic        e_busy, e_trn, e_conv, e_to;
    logic [5:0]  e_cnt;
    logic [15:0] e_rd, e0, e1, e2;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic dir, logic st, logic wr, logic [1:0] sel, logic [15:0] wd,
                              logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                              logic eb, logic et, logic ec, logic eto, logic [5:0] ecnt,
                              logic [15:0] erd, logic [15:0] e0, logic [15:0] e1, logic [15:0] e2);
    vec_t v;
    v.dir = dir; v.st = st; v.wr = wr; v.sel = sel; v.wd = wd;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.e_busy = eb; v.e_trn = et; v.e_conv = ec; v.e_to = eto; v.e_cnt = ecnt;
    v.e_rd = erd; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic eb, input logic et, input logic ec,
                           input logic eto, input logic [5:0] ecnt);
    chk({tag, ".busy"}, {15'h0, busy}, {15'h0, eb});
    chk({tag, ".trn_reset"}, {15'h0, trn_reset}, {15'h0, et});
    chk({tag, ".converged"}, {15'h0, converged}, {15'h0, ec});
    chk({tag, ".timeout"}, {15'h0, timeout}, {15'h0, eto});
    chk({tag, ".epoch_count"}, {10'h0, epoch_count}, {10'h0, ecnt});
  endtask

  initial begin
    logic [15:0] prev0;
    logic [15:0] a0, a1, a2;

    // Vectors: inputs applied for one edge, outputs checked just after it.
    add(0,0,0,0,16'h0,    0,0,0, 0,1,0,0,0, 16'h3C00, 16'h3C00,16'h3C00,16'h3C00);
    add(0,0,1,3,16'hFFFF, 0,0,0, 0,1,0,0,0, 16'h0000, 16'h3C00,16'h3C00,16'h3C00);
    add(0,0,1,1,16'h4000, 0,0,0, 0,1,0,0,0, 16'h4000, 16'h3C00,16'h4000,16'h3C00);
    add(0,1,0,1,16'h0,    0,0,0, 1,1,0,0,0, 16'h4000, 16'h3C00,16'h4000,16'h3C00);
    add(0,0,1,1,16'h3800, 0,0,0, 1,0,0,0,0, 16'h4000, 16'h3C00,16'h4000,16'h3C00);
    add(0,0,1,1,16'h3800, 0,0,0, 1,0,0,0,0, 16'h4000, 16'h3C00,16'h4000,16'h3C00);
    for (int i = 0; i < 3; i++)
      add(1,0,0,1,16'h0, 16'h3800,16'h3C00,16'h4000, 1,0,0,0,0, 16'h4000, 0,0,0);
    add(0,0,0,1,16'h0, 0,0,0, 1,0,0,0,1, 16'h3C00, 16'h3800,16'h3C00,16'h4000);
    for (int i = 0; i < 2; i++)
      add(1,0,0,1,16'h0, 16'h3800,16'h3C00,16'h4000, 1,0,0,0,1, 16'h3C00, 0,0,0);
    add(0,0,0,1,16'h0, 0,0,0, 0,1,1,0,2, 16'h3C00, 16'h3800,16'h3C00,16'h4000);
    add(0,1,0,0,16'h0, 0,0,0, 1,1,0,0,0, 16'h3800, 16'h3800,16'h3C00,16'h4000);
    add(0,0,0,0,16'h0, 0,0,0, 1,0,0,0,0, 16'h3800, 16'h3800,16'h3C00,16'h4000);
    prev0 = 16'h3800;
    for (int k = 1; k <= 4; k++) begin
      a0 = 16'h4100 + 16'(16'h0300 * (k - 1));
      a1 = a0 + 16'h0100;
      a2 = a0 + 16'h0200;
      add(1,0,0,0,16'h0, a0,a1,a2, 1,0,0,0,6'(k-1), prev0, 0,0,0);
      if (k < 4) add(0,0,0,0,16'h0, 0,0,0, 1,0,0,0,6'(k), a0, a0,a1,a2);
      else       add(0,0,0,0,16'h0, 0,0,0, 0,1,0,1,6'(k), a0, a0,a1,a2);
      prev0 = a0;
    end
    // Capture outside RUN, epoch end in DONE and in LOAD: none of them counts or commits.
    add(1,0,0,0,16'h0, 16'h5000,16'h5000,16'h5000, 0,1,0,1,4, 16'h4A00, 0,0,0);
    add(0,0,0,0,16'h0, 0,0,0, 0,1,0,1,4, 16'h4A00, 16'h4A00,16'h4B00,16'h4C00);
    add(1,1,0,0,16'h0, 16'h5000,16'h5000,16'h5000, 1,1,0,0,0, 16'h4A00, 0,0,0);
    add(0,0,0,0,16'h0, 0,0,0, 1,0,0,0,0, 16'h4A00, 16'h4A00,16'h4B00,16'h4C00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 0, 1, 0, 0, 0);
    chk("reset.rdata", host_rdata, 16'h3C00);
    chk("reset.bus_w0", w0, 16'h3C00);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      direction = vq[i].dir; start = vq[i].st; host_wr_en = vq[i].wr;
      host_sel = vq[i].sel; host_wdata = vq[i].wd;
      tb_w0 = vq[i].d0; tb_w1 = vq[i].d1; tb_w2 = vq[i].d2;
      tick();
      chk_flags(tag, vq[i].e_busy, vq[i].e_trn, vq[i].e_conv, vq[i].e_to, vq[i].e_cnt);
      chk({tag, ".rdata"}, host_rdata, vq[i].e_rd);
      if (!vq[i].dir) begin
        chk({tag, ".bus_w0"}, w0, vq[i].e0);
        chk({tag, ".bus_w1"}, w1, vq[i].e1);
        chk({tag, ".bus_w2"}, w2, vq[i].e2);
      end
    end
    start = 1'b0; host_wr_en = 1'b0;

    // Async reset mid-RUN while the trainer owns the bus
    direction = 1'b1; tb_w0 = 16'h1234; tb_w1 = 16'h1234; tb_w2 = 16'h1234;
    tick();
    #2 reset = 1'b0;
    #1;
    chk_flags("async_rst", 0, 1, 0, 0, 0);
    host_sel = 2'd0;
    #1 chk("async_rst.rdata", host_rdata, 16'h3C00);
    direction = 1'b0;
    #1;
    chk("async_rst.bus_w0", w0, 16'h3C00);
    chk("async_rst.bus_w1", w1, 16'h3C00);
    chk("async_rst.bus_w2", w2, 16'h3C00);
    @(negedge clk);
    reset = 1'b1;

    // Host write and start on the same edge: write lands, LOAD drives it
    tick();
    host_wr_en = 1'b1; host_sel = 2'd2; host_wdata = 16'h5555; start = 1'b1;
    tick();
    host_wr_en = 1'b0; start = 1'b0;
    chk("wr_start.busy", {15'h0, busy}, 16'h0001);
    chk("wr_start.trn_reset", {15'h0, trn_reset}, 16'h0001);
    chk("wr_start.rdata", host_rdata, 16'h5555);
    chk("wr_start.bus_w2", w2, 16'h5555);
    chk("wr_start.bus_w0", w0, 16'h3C00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
